// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the fetch path: opcodes, status codes and fetch FSM states.
package y86_pkg;

    localparam logic [3:0] INOP    = 4'h0;
    localparam logic [3:0] IHALT   = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'ha;
    localparam logic [3:0] IPOPQ   = 4'hb;

    localparam logic [3:0] RNONE = 4'hf;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    typedef enum logic [2:0] {
        ST_OPCODE = 3'd0,
        ST_REGS   = 3'd1,
        ST_CONST  = 3'd2,
        ST_HOLD   = 3'd3,
        ST_HALTED = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/fetch_len_decode.sv
// Combinational instruction-shape decode: which optional bytes follow the opcode and total length.
module fetch_len_decode
    import y86_pkg::*;
(
    input  logic [3:0] icode_i,
    output logic       need_regids_o,
    output logic       need_valc_o,
    output logic [1:0] valc_off_o,
    output logic [3:0] len_o,
    output logic       valid_o
);

    // Opcode to instruction layout; unknown opcodes report length 0 and valid low.
    always_comb begin
        need_regids_o = 1'b0;
        need_valc_o   = 1'b0;
        valc_off_o    = 2'd0;
        len_o         = 4'd0;
        valid_o       = 1'b0;
        case (icode_i)
            INOP, IHALT, IRET: begin
                len_o   = 4'd1;
                valid_o = 1'b1;
            end
            IRRMOVQ, IOPQ, IPUSHQ, IPOPQ: begin
                need_regids_o = 1'b1;
                len_o         = 4'd2;
                valid_o       = 1'b1;
            end
            IJXX, ICALL: begin
                need_valc_o = 1'b1;
                valc_off_o  = 2'd1;
                len_o       = 4'd9;
                valid_o     = 1'b1;
            end
            IIRMOVQ, IRMMOVQ, IMRMOVQ: begin
                need_regids_o = 1'b1;
                need_valc_o   = 1'b1;
                valc_off_o    = 2'd2;
                len_o         = 4'd10;
                valid_o       = 1'b1;
            end
            default: begin
                valid_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle Y86-64 fetch: reads one instruction byte per handshake, assembles the record,
// and offers it downstream over valid/ready; stops for good on halt/ADR/INS.
module fetch_sequencer
    import y86_pkg::*;
#(
    parameter int unsigned IMEM_BYTES = 1024,
    parameter logic [63:0] RESET_PC   = 64'd0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        mem_req_o,
    output logic [63:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [7:0]  mem_rdata_i,
    input  logic        pc_load_i,
    input  logic [63:0] pc_new_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [3:0]  icode_o,
    output logic [3:0]  ifun_o,
    output logic [3:0]  ra_o,
    output logic [3:0]  rb_o,
    output logic [63:0] valc_o,
    output logic [63:0] valp_o,
    output logic [2:0]  stat_o
);

    localparam logic [63:0] IMEM_LIMIT = 64'(IMEM_BYTES);

    fetch_state_e state_q, state_d;
    logic [63:0]  pc_q, pc_d, valc_q, valc_d, valp_q, valp_d, mem_addr_q, mem_addr_d;
    logic [3:0]   icode_q, icode_d, ifun_q, ifun_d, ra_q, ra_d, rb_q, rb_d;
    logic [2:0]   k_q, k_d, stat_q, stat_d;
    logic         mem_req_q, mem_req_d;

    logic         ack_s, accept_s, redirect_s;
    logic [3:0]   dec_icode_s, dec_len_s;
    logic         dec_need_regids_s, dec_need_valc_s, dec_valid_s;
    logic [1:0]   dec_valc_off_s;
    logic [63:0]  fetch_addr_s;

    assign ack_s       = mem_req_q & mem_ack_i;
    assign accept_s    = (state_q == ST_HOLD) & out_ready_i;
    // The opcode byte is decoded as it arrives; afterwards the latched opcode drives the decoder.
    assign dec_icode_s = (state_q == ST_OPCODE) ? mem_rdata_i[7:4] : icode_q;

    fetch_len_decode u_len_decode (
        .icode_i       (dec_icode_s),
        .need_regids_o (dec_need_regids_s),
        .need_valc_o   (dec_need_valc_s),
        .valc_off_o    (dec_valc_off_s),
        .len_o         (dec_len_s),
        .valid_o       (dec_valid_s)
    );

    assign redirect_s = pc_load_i && (state_q != ST_HALTED)
                        && !(accept_s && (stat_q != SAOK));

    // Next-state, field capture, redirect override and the address check for the next byte.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        k_d          = k_q;
        icode_d      = icode_q;
        ifun_d       = ifun_q;
        ra_d         = ra_q;
        rb_d         = rb_q;
        valc_d       = valc_q;
        valp_d       = valp_q;
        stat_d       = stat_q;
        mem_req_d    = 1'b0;
        mem_addr_d   = mem_addr_q;
        fetch_addr_s = 64'd0;

        case (state_q)
            ST_OPCODE: begin
                if (ack_s) begin
                    icode_d = mem_rdata_i[7:4];
                    ifun_d  = mem_rdata_i[3:0];
                    if (!dec_valid_s) begin
                        stat_d  = SINS;
                        valp_d  = pc_q;
                        state_d = ST_HOLD;
                    end else if (mem_rdata_i[7:4] == IHALT) begin
                        stat_d  = SHLT;
                        valp_d  = pc_q + 64'd1;
                        state_d = ST_HOLD;
                    end else if (dec_need_regids_s) begin
                        state_d = ST_REGS;
                    end else if (dec_need_valc_s) begin
                        k_d     = 3'd0;
                        state_d = ST_CONST;
                    end else begin
                        valp_d  = pc_q + {60'd0, dec_len_s};
                        state_d = ST_HOLD;
                    end
                end else begin
                    state_d = ST_OPCODE;
                end
            end
            ST_REGS: begin
                if (ack_s) begin
                    ra_d = mem_rdata_i[7:4];
                    rb_d = mem_rdata_i[3:0];
                    if (dec_need_valc_s) begin
                        k_d     = 3'd0;
                        state_d = ST_CONST;
                    end else begin
                        valp_d  = pc_q + {60'd0, dec_len_s};
                        state_d = ST_HOLD;
                    end
                end else begin
                    state_d = ST_REGS;
                end
            end
            ST_CONST: begin
                if (ack_s) begin
                    valc_d[{k_q, 3'b000} +: 8] = mem_rdata_i;
                    if (k_q == 3'd7) begin
                        valp_d  = pc_q + {60'd0, dec_len_s};
                        state_d = ST_HOLD;
                    end else begin
                        k_d = k_q + 3'd1;
                    end
                end else begin
                    state_d = ST_CONST;
                end
            end
            ST_HOLD: begin
                if (accept_s && (stat_q == SAOK)) begin
                    pc_d    = valp_q;
                    ra_d    = RNONE;
                    rb_d    = RNONE;
                    valc_d  = 64'd0;
                    state_d = ST_OPCODE;
                end else if (accept_s) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_HALTED;
            end
        endcase

        // A redirect discards any byte acked this cycle and any unaccepted record.
        if (redirect_s) begin
            state_d = ST_OPCODE;
            pc_d    = pc_new_i;
            k_d     = 3'd0;
            icode_d = 4'd0;
            ifun_d  = 4'd0;
            ra_d    = RNONE;
            rb_d    = RNONE;
            valc_d  = 64'd0;
            valp_d  = 64'd0;
            stat_d  = SAOK;
        end else begin
            stat_d = stat_d;
        end

        case (state_d)
            ST_OPCODE: fetch_addr_s = pc_d;
            ST_REGS:   fetch_addr_s = pc_d + 64'd1;
            ST_CONST:  fetch_addr_s = pc_d + {62'd0, dec_valc_off_s} + {61'd0, k_d};
            default:   fetch_addr_s = 64'd0;
        endcase

        if ((state_d == ST_OPCODE) || (state_d == ST_REGS) || (state_d == ST_CONST)) begin
            if (fetch_addr_s >= IMEM_LIMIT) begin
                stat_d  = SADR;
                valp_d  = pc_d + {60'd0, dec_len_s};
                state_d = ST_HOLD;
            end else begin
                mem_req_d  = 1'b1;
                mem_addr_d = fetch_addr_s;
            end
        end else begin
            mem_req_d = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_OPCODE;
            pc_q       <= RESET_PC;
            k_q        <= 3'd0;
            icode_q    <= 4'd0;
            ifun_q     <= 4'd0;
            ra_q       <= RNONE;
            rb_q       <= RNONE;
            valc_q     <= 64'd0;
            valp_q     <= 64'd0;
            stat_q     <= SAOK;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            k_q        <= k_d;
            icode_q    <= icode_d;
            ifun_q     <= ifun_d;
            ra_q       <= ra_d;
            rb_q       <= rb_d;
            valc_q     <= valc_d;
            valp_q     <= valp_d;
            stat_q     <= stat_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_addr_o  = mem_addr_q;
    assign out_valid_o = (state_q == ST_HOLD);
    assign icode_o     = icode_q;
    assign ifun_o      = ifun_q;
    assign ra_o        = ra_q;
    assign rb_o        = rb_q;
    assign valc_o      = valc_q;
    assign valp_o      = valp_q;
    assign stat_o      = stat_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a random program with
// random memory wait states and backpressure, checked against a byte-walking reference model.
module tb_fetch_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, mem_req, mem_ack, pc_load, out_valid, out_ready;
    logic [63:0] mem_addr, pc_new, valc, valp;
    logic [7:0]  mem_rdata;
    logic [3:0]  icode, ifun, ra, rb;
    logic [2:0]  stat;

    logic        rst2_n, mem_req2, mem_ack2, pc_load2, out_valid2, out_ready2;
    logic [63:0] mem_addr2, pc_new2, valc2, valp2;
    logic [7:0]  mem_rdata2;
    logic [3:0]  icode2, ifun2, ra2, rb2;
    logic [2:0]  stat2;

    logic [7:0] mem [0:1023];
    assign mem_rdata  = (mem_addr  < 64'd1024) ? mem[mem_addr[9:0]]  : 8'h00;
    assign mem_rdata2 = (mem_addr2 < 64'd1024) ? mem[mem_addr2[9:0]] : 8'h00;

    fetch_sequencer #(.IMEM_BYTES(1024), .RESET_PC(64'd0)) dut (
        .clk_i(clk), .rst_ni(rst_n), .mem_req_o(mem_req), .mem_addr_o(mem_addr),
        .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata), .pc_load_i(pc_load), .pc_new_i(pc_new),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .icode_o(icode), .ifun_o(ifun),
        .ra_o(ra), .rb_o(rb), .valc_o(valc), .valp_o(valp), .stat_o(stat));

    fetch_sequencer #(.IMEM_BYTES(1024), .RESET_PC(64'd1020)) dut_hi (
        .clk_i(clk), .rst_ni(rst2_n), .mem_req_o(mem_req2), .mem_addr_o(mem_addr2),
        .mem_ack_i(mem_ack2), .mem_rdata_i(mem_rdata2), .pc_load_i(pc_load2), .pc_new_i(pc_new2),
        .out_valid_o(out_valid2), .out_ready_i(out_ready2), .icode_o(icode2), .ifun_o(ifun2),
        .ra_o(ra2), .rb_o(rb2), .valc_o(valc2), .valp_o(valp2), .stat_o(stat2));

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic [2:0]  stat;
    } rec_t;

    int n_cmp = 0;
    int n_bad = 0;
    bit ack_always = 1'b1;

    localparam logic [146:0] RESET_REC = {4'h0, 4'h0, 4'hf, 4'hf, 64'd0, 64'd0, 3'd1};

    // Reference: walk the instruction's bytes in memory and build the record it should produce.
    function automatic rec_t ref_fetch(input logic [63:0] pc);
        rec_t r;
        int len, off;
        bit regs;
        logic [7:0] b;
        logic [63:0] a;
        r = '{icode: 4'h0, ifun: 4'h0, ra: 4'hf, rb: 4'hf, valc: 64'd0, valp: 64'd0, stat: 3'd1};
        if (pc >= 64'd1024) begin r.stat = 3'd3; return r; end
        b = mem[pc[9:0]];
        r.icode = b[7:4];
        r.ifun  = b[3:0];
        case (r.icode)
            4'h0, 4'h1, 4'h9:       begin len = 1;  regs = 1'b0; off = 0; end
            4'h2, 4'h6, 4'ha, 4'hb: begin len = 2;  regs = 1'b1; off = 0; end
            4'h7, 4'h8:             begin len = 9;  regs = 1'b0; off = 1; end
            4'h3, 4'h4, 4'h5:       begin len = 10; regs = 1'b1; off = 2; end
            default: begin r.stat = 3'd4; r.valp = pc; return r; end
        endcase
        if (r.icode == 4'h1) begin r.stat = 3'd2; r.valp = pc + 64'd1; return r; end
        for (int i = 1; i < len; i++) begin
            a = pc + 64'(i);
            if (a >= 64'd1024) begin r.stat = 3'd3; return r; end
            b = mem[a[9:0]];
            if (regs && i == 1) begin r.ra = b[7:4]; r.rb = b[3:0]; end
            else r.valc[8*(i-off) +: 8] = b;
        end
        r.valp = pc + 64'(len);
        return r;
    endfunction

    function automatic rec_t dut_rec();
        rec_t r;
        r = '{icode: icode, ifun: ifun, ra: ra, rb: rb, valc: valc, valp: valp, stat: stat};
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        mem_ack  = mem_req  && (ack_always || ($urandom_range(0, 1) == 1));
        mem_ack2 = mem_req2 && (ack_always || ($urandom_range(0, 1) == 1));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; pc_load = 1'b0; out_ready = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (out_valid === 1'b1) begin ok = 1'b1; break; end
            step();
        end
    endtask

    task automatic test_reset();
        clear_mem(); ack_always = 1'b1;
        do_reset();
        n_cmp++;
        if ({mem_req, mem_addr, out_valid, dut_rec()} !== {1'b0, 64'd0, 1'b0, RESET_REC}) begin
            n_bad++; $display("FAIL reset_state: got req=%b addr=%h valid=%b rec=%h exp req=0 addr=0 valid=0 rec=%h",
                              mem_req, mem_addr, out_valid, dut_rec(), RESET_REC);
        end
        step();
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 64'd0) begin
            n_bad++; $display("FAIL reset_restart: got req=%b addr=%h exp req=1 addr=0", mem_req, mem_addr);
        end
    endtask

    task automatic test_irmovq();
        int cnt;
        clear_mem();
        mem[0] = 8'h30; mem[1] = 8'hf0; mem[2] = 8'h0c;
        ack_always = 1'b1;
        do_reset(); out_ready = 1'b1;
        step();
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < 50) begin step(); cnt++; end
        n_cmp++;
        if (cnt !== 10) begin n_bad++; $display("FAIL irmovq_latency: got %0d cycles exp 10", cnt); end
        n_cmp++;
        if (dut_rec() !== {4'h3, 4'h0, 4'hf, 4'h0, 64'd12, 64'd10, 3'd1}) begin
            n_bad++; $display("FAIL irmovq_record: got %h exp %h", dut_rec(),
                              {4'h3, 4'h0, 4'hf, 4'h0, 64'd12, 64'd10, 3'd1});
        end
        step();
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 64'd10 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL irmovq_next_req: got req=%b addr=%h valid=%b exp 1/10/0", mem_req, mem_addr, out_valid);
        end
    endtask

    task automatic test_sequence();
        logic [63:0] vp [4];
        logic [63:0] pc;
        rec_t exp;
        bit ok;
        vp = '{64'd1, 64'd3, 64'd12, 64'h41};
        clear_mem();
        mem[1] = 8'h60; mem[2] = 8'h01; mem[3] = 8'h70; mem[4] = 8'h40; mem[64] = 8'h10;
        ack_always = 1'b0;
        do_reset(); out_ready = 1'b1;
        pc = 64'd0;
        for (int k = 0; k < 4; k++) begin
            exp = ref_fetch(pc);
            wait_valid(200, ok);
            n_cmp++;
            if (!ok || dut_rec() !== exp || valp !== vp[k]) begin
                n_bad++; $display("FAIL seq_record%0d: got %h valid=%b exp %h valP %h", k, dut_rec(), out_valid, exp, vp[k]);
            end
            if (exp.icode == 4'h7) begin pc_load = 1'b1; pc_new = 64'h40; pc = 64'h40; end
            else pc = exp.valp;
            step();
            pc_load = 1'b0;
        end
        for (int i = 0; i < 20; i++) begin
            n_cmp++;
            if (mem_req !== 1'b0 || out_valid !== 1'b0) begin
                n_bad++; $display("FAIL seq_halted: got req=%b valid=%b exp 0/0", mem_req, out_valid);
            end
            step();
        end
    endtask

    task automatic test_invalid();
        rec_t exp;
        bit ok;
        clear_mem(); mem[0] = 8'hf0;
        ack_always = 1'b0;
        do_reset();
        exp = ref_fetch(64'd0);
        wait_valid(100, ok);
        n_cmp++;
        if (!ok || dut_rec() !== exp || stat !== 3'd4 || valp !== 64'd0) begin
            n_bad++; $display("FAIL ins_record: got %h valid=%b exp %h", dut_rec(), out_valid, exp);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pc_load = (i % 2 == 0); pc_new = 64'd0;
            step();
            n_cmp++;
            if (mem_req !== 1'b0 || out_valid !== 1'b0) begin
                n_bad++; $display("FAIL ins_halted: got req=%b valid=%b exp 0/0", mem_req, out_valid);
            end
        end
        pc_load = 1'b0;
    endtask

    task automatic test_adr();
        rec_t exp;
        bit ok, bad_req;
        clear_mem();
        mem[1020] = 8'h30; mem[1021] = 8'hf2; mem[1022] = 8'h34; mem[1023] = 8'h12;
        ack_always = 1'b0; out_ready2 = 1'b0;
        rst2_n = 1'b0; step(); rst2_n = 1'b1;
        exp = ref_fetch(64'd1020);
        ok = 1'b0; bad_req = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (mem_req2 === 1'b1 && mem_addr2 >= 64'd1024) bad_req = 1'b1;
            if (out_valid2 === 1'b1) begin ok = 1'b1; break; end
            step();
        end
        n_cmp++;
        if (!ok || bad_req) begin n_bad++; $display("FAIL adr_fetch: got valid=%b req_over_limit=%b exp 1/0", ok, bad_req); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if ({out_valid2, icode2, ifun2, ra2, rb2, valc2, stat2} !==
                {1'b1, exp.icode, exp.ifun, exp.ra, exp.rb, exp.valc, 3'd3}) begin
                n_bad++; $display("FAIL adr_hold%0d: got v=%b ic=%h if=%h rA=%h rB=%h valC=%h stat=%0d exp ic=%h rB=%h valC=%h stat=3",
                                  i, out_valid2, icode2, ifun2, ra2, rb2, valc2, stat2, exp.icode, exp.rb, exp.valc);
            end
            if (i < 5) step();
        end
        out_ready2 = 1'b1; step(); out_ready2 = 1'b0;
        n_cmp++;
        if (out_valid2 !== 1'b0 || mem_req2 !== 1'b0) begin
            n_bad++; $display("FAIL adr_halted: got valid=%b req=%b exp 0/0", out_valid2, mem_req2);
        end
    endtask

    task automatic test_redirect();
        rec_t exp;
        bit ok;
        clear_mem();
        mem[0] = 8'h30; mem[1] = 8'hf3;
        for (int i = 2; i < 10; i++) mem[i] = 8'(i * 17);
        mem[32] = 8'h80; mem[33] = 8'h34; mem[34] = 8'h12;
        ack_always = 1'b1;
        do_reset(); out_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (mem_req === 1'b1 && mem_addr === 64'd5) begin ok = 1'b1; break; end
            step();
        end
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL redir_reach_k3: got not reached exp reached"); end
        pc_load = 1'b1; pc_new = 64'h20;
        step();
        pc_load = 1'b0;
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 64'h20 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL redir_req: got req=%b addr=%h valid=%b exp 1/20/0", mem_req, mem_addr, out_valid);
        end
        exp = ref_fetch(64'h20);
        wait_valid(50, ok);
        n_cmp++;
        if (!ok || dut_rec() !== exp) begin n_bad++; $display("FAIL redir_record: got %h exp %h", dut_rec(), exp); end
        step();
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_mem(); mem[0] = 8'h30; mem[1] = 8'hf1; mem[5] = 8'h77;
        ack_always = 1'b0;
        do_reset();
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (mem_req === 1'b1 && mem_addr === 64'd6) begin ok = 1'b1; break; end
            step();
        end
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL rstmid_reach: got not reached exp reached"); end
        rst_n = 1'b0; step(); rst_n = 1'b1;
        n_cmp++;
        if ({mem_req, mem_addr, out_valid, dut_rec()} !== {1'b0, 64'd0, 1'b0, RESET_REC}) begin
            n_bad++; $display("FAIL rstmid_state: got req=%b addr=%h valid=%b rec=%h exp 0/0/0 rec=%h", mem_req, mem_addr, out_valid, dut_rec(), RESET_REC);
        end
        step();
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 64'd0) begin n_bad++; $display("FAIL rstmid_restart: got req=%b addr=%h exp 1/0", mem_req, mem_addr); end
        mem[0] = 8'h10;
        do_reset(); out_ready = 1'b1;
        wait_valid(100, ok);
        n_cmp++;
        if (!ok || stat !== 3'd2) begin n_bad++; $display("FAIL rsthalt_stat: got valid=%b stat=%0d exp 1/2", out_valid, stat); end
        step(); step();
        n_cmp++;
        if (mem_req !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL rsthalt_halted: got req=%b valid=%b exp 0/0", mem_req, out_valid); end
        rst_n = 1'b0; step(); rst_n = 1'b1;
        n_cmp++;
        if ({mem_req, mem_addr, out_valid, dut_rec()} !== {1'b0, 64'd0, 1'b0, RESET_REC}) begin
            n_bad++; $display("FAIL rsthalt_state: got req=%b addr=%h valid=%b rec=%h exp 0/0/0 rec=%h", mem_req, mem_addr, out_valid, dut_rec(), RESET_REC);
        end
        step();
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 64'd0) begin n_bad++; $display("FAIL rsthalt_restart: got req=%b addr=%h exp 1/0", mem_req, mem_addr); end
    endtask

    task automatic test_random_program();
        logic [3:0] ops [11];
        logic [63:0] pc, prev_addr;
        rec_t exp;
        bit ok, prev_pend;
        int stab_bad;
        ops = '{4'h0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'ha, 4'hb};
        clear_mem();
        pc = 64'd0;
        for (int n = 0; n < 60; n++) begin
            mem[pc[9:0]] = {ops[$urandom_range(0, 10)], 4'($urandom_range(0, 15))};
            exp = ref_fetch(pc);
            for (int i = 1; i < 10; i++) mem[pc[9:0] + 10'(i)] = 8'($urandom);
            pc = exp.valp;
        end
        ack_always = 1'b0;
        do_reset();
        pc = 64'd0; stab_bad = 0; prev_pend = 1'b0; prev_addr = 64'd0;
        for (int n = 0; n < 60; n++) begin
            exp = ref_fetch(pc);
            ok = 1'b0;
            for (int c = 0; c < 300; c++) begin
                out_ready = ($urandom_range(0, 1) == 1);
                if (prev_pend && mem_addr !== prev_addr) stab_bad++;
                if (out_valid === 1'b1 && out_ready) begin
                    ok = 1'b1;
                    n_cmp++;
                    if (dut_rec() !== exp) begin n_bad++; $display("FAIL rand_record%0d at pc %h: got %h exp %h", n, pc, dut_rec(), exp); end
                end
                prev_pend = mem_req && !mem_ack;
                prev_addr = mem_addr;
                step();
                if (ok) break;
            end
            if (!ok) begin n_cmp++; n_bad++; $display("FAIL rand_timeout%0d: got no record exp record at pc %h", n, pc); break; end
            pc = exp.valp;
        end
        out_ready = 1'b0;
        n_cmp++;
        if (stab_bad != 0) begin n_bad++; $display("FAIL rand_addr_stable: got %0d changes while waiting exp 0", stab_bad); end
    endtask

    initial begin
        rst_n = 1'b0; mem_ack = 1'b0; pc_load = 1'b0; pc_new = 64'd0; out_ready = 1'b0;
        rst2_n = 1'b0; mem_ack2 = 1'b0; pc_load2 = 1'b0; pc_new2 = 64'd0; out_ready2 = 1'b0;
        clear_mem();
        step();
        test_reset();
        test_irmovq();
        test_sequence();
        test_invalid();
        test_adr();
        test_redirect();
        test_reset_mid();
        test_random_program();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
